prog_counter_ip: RTL and testbench
==================================

# prog_counter_ip

Parametrised, programmable up/down counter that succeeds the basic load/enable counter in the timer and event-counting subsystem. It adds a programmable terminal value (limit), a count direction, three terminal behaviours (wrap, saturate, one-shot), an enable prescaler, and registered terminal-count and done indications. Instances sit beside peripheral control registers and are driven directly by software-visible configuration fields.

## Interface
Parameters:
- `WIDTH`, default 16: width of the count, load value and limit.
- `PRESCALE_WIDTH`, default 8: width of the prescaler divisor and its internal counter.

Ports:
- `clk_i`  input  1: single clock; all logic is rising-edge.
- `reset_n`  input  1: reset, asynchronous, active-low.
- `clear_i`  input  1: synchronous clear of count, prescaler and `done_o`.
- `load_i`  input  1: synchronous load of `load_value_i`.
- `load_value_i`  input  WIDTH: value written by `load_i`.
- `enable_i`  input  1: advances the prescaler; the count holds while low.
- `dir_i`  input  1: count direction; 0 = up, 1 = down.
- `mode_i`  input  2: terminal behaviour; 00 = wrap, 01 = saturate, 10 = one-shot, 11 = treated as wrap.
- `limit_i`  input  WIDTH: upper bound of the count range 0..limit.
- `prescale_i`  input  PRESCALE_WIDTH: the count steps once every `prescale_i`+1 enabled cycles.
- `count_o`  output  WIDTH: current count (registered).
- `tc_o`  output  1: one-cycle terminal-count pulse (registered).
- `done_o`  output  1: sticky one-shot completion flag (registered).

## Operation
- **Reset.** Asserting `reset_n` low immediately forces `count_o`=0, `tc_o`=0, `done_o`=0 and prescaler=0, with no clock edge needed.
- **Priority per edge.** `clear_i` > `load_i` > tick > hold.
- **Clear.** `count_o`=0, prescaler=0, `done_o`=0, `tc_o`=0.
- **Load.** `count_o`=`load_value_i`, prescaler=0, `done_o`=0, `tc_o`=0.
  - The load value is not clamped to `limit_i`.
  - A tick in the same cycle is discarded.
- **Prescaler.** Evaluated only while `enable_i`=1 and neither clear nor load is active.
  - If prescaler==`prescale_i`: prescaler←0 and a tick occurs.
  - Otherwise: prescaler←prescaler+1.
  - With `enable_i`=0 the prescaler holds.
  - `prescale_i`=0 gives a tick on every enabled cycle.
  - A change to `prescale_i` takes effect at the next compare. If the prescaler is already above the new value, it counts up, wraps mod 2^PRESCALE_WIDTH, then matches.
- **Terminal value.** `limit_i` when counting up; 0 when counting down. The comparison is equality against the current `count_o`.
- **Tick, count not at terminal.** Up: count+1; down: count−1. Arithmetic is mod 2^WIDTH.
  - Counting up from above `limit_i` runs to all-ones, then wraps to 0 with no `tc_o`.
- **Tick, count at terminal:**
  - wrap: up → 0, down → `limit_i`; `tc_o`=1 for one cycle.
  - saturate: count holds; `tc_o`=1 on every tick taken at terminal.
  - one-shot, `done_o`=0: count holds; `tc_o`=1 once; `done_o`←1.
- **One-shot after done.** While `done_o`=1 in one-shot mode, ticks are ignored (no count change, no `tc_o`).
  - Only clear, load or reset releases `done_o`.
  - `done_o` stays set if the mode changes; ticks resume under the new mode.
- **Configuration changes.** `dir_i`, `mode_i` and `limit_i` are sampled on every tick with no shadowing. A direction change applies to the next tick.
- **No tick.** Count holds and `tc_o`=0.

## Timing
- Latency from the clock edge that takes a tick to the new `count_o` is zero cycles: the registered value is visible after that edge.
- `tc_o` rises on the same edge as the post-terminal count and is high for exactly one cycle. Back-to-back pulses occur only in saturate or wrap with `prescale_i`=0 and `limit_i`=0.
- `done_o` rises on the same edge as the final one-shot `tc_o`.
- Clear and load take effect on the edge that samples them. All outputs are glitch-free register outputs.
- If reset asserts mid-count, all state is lost. After deassertion the first tick needs `prescale_i`+1 enabled cycles.

## Test plan
- **Async reset.** Counting at 0x0042, drive `reset_n` low between edges → `count_o`=0, `tc_o`=0, `done_o`=0 before the next edge; values hold until release.
- **Wrap up.** `limit_i`=9, `prescale_i`=0, `mode_i`=00, `dir_i`=0, enable for 12 cycles from 0 → 0,1,…,9,0,1; `tc_o` high only in the cycle where the count returns to 0.
- **Wrap down, with priority.**
  - Load 2 with `dir_i`=1, `limit_i`=5 → 2,1,0,5,4; `tc_o` coincides with 5.
  - Assert `clear_i` and `load_i` together → `count_o`=0.
- **Prescaler.** `prescale_i`=3 → the count steps every 4th enabled cycle. Dropping `enable_i` for 2 cycles mid-period delays the step by exactly 2 cycles.
- **One-shot.**
  - `mode_i`=10, `limit_i`=3, up from 0 → 0,1,2,3 held.
  - Next tick → one `tc_o`, `done_o`=1; 5 further ticks cause no change and no `tc_o`.
  - Load 0 → `done_o`=0 and counting resumes.
- **Saturate and above-limit.**
  - Saturate down from 1 → 0 held, with `tc_o` on each further tick.
  - Wrap up: load 0xFFFE with `limit_i`=9 → 0xFFFF, 0x0000 with no `tc_o`, then normal wrap at 9.

Source files
------------

// File: rtl/prog_counter_ip.sv
// prog_counter_ip: programmable up/down counter with limit, terminal modes, prescaler, tc and done flags
module prog_counter_ip #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n,
  input  logic                      clear_i,
  input  logic                      load_i,
  input  logic [WIDTH-1:0]          load_value_i,
  input  logic                      enable_i,
  input  logic                      dir_i,
  input  logic [1:0]                mode_i,
  input  logic [WIDTH-1:0]          limit_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [WIDTH-1:0]          count_o,
  output logic                      tc_o,
  output logic                      done_o
);
  localparam logic [WIDTH-1:0]          CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  logic [WIDTH-1:0]          count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      tc_q, tc_d, done_q, done_d;
  logic                      hit, tick, at_term, sat, one_shot;
  assign hit      = pre_q == prescale_i;
  assign tick     = enable_i && hit;
  assign at_term  = dir_i ? (count_q == '0) : (count_q == limit_i);
  assign sat      = mode_i == 2'b01;
  assign one_shot = mode_i == 2'b10;
  // Next state: clear beats load beats tick; a finished one-shot swallows ticks
  always_comb begin
    pre_d   = enable_i ? (hit ? '0 : pre_q + PRE_ONE) : pre_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (tick && !(one_shot && done_q)) begin
      if (!at_term) count_d = dir_i ? count_q - CNT_ONE : count_q + CNT_ONE;
      else begin
        tc_d    = 1'b1;
        count_d = (sat || one_shot) ? count_q : (dir_i ? limit_i : '0);
        done_d  = done_q | one_shot;
      end
    end
    if (clear_i || load_i) begin
      count_d = clear_i ? '0 : load_value_i;
      pre_d   = '0;
      tc_d    = 1'b0;
      done_d  = 1'b0;
    end
  end
  // State registers, asynchronously cleared
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end
  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;
endmodule

// File: tb/tb_prog_counter_ip.sv
// tb_prog_counter_ip: directed self-checking bench for prog_counter_ip
module tb_prog_counter_ip;
  logic        clk_i = 1'b0;
  logic        reset_n;
  logic        clear_i, load_i, enable_i, dir_i;
  logic [15:0] load_value_i, limit_i, count_o;
  logic [1:0]  mode_i;
  logic [7:0]  prescale_i;
  logic        tc_o, done_o;
  int          checks = 0;
  int          errors = 0;

  prog_counter_ip dut (
    .clk_i(clk_i), .reset_n(reset_n), .clear_i(clear_i), .load_i(load_i),
    .load_value_i(load_value_i), .enable_i(enable_i), .dir_i(dir_i),
    .mode_i(mode_i), .limit_i(limit_i), .prescale_i(prescale_i),
    .count_o(count_o), .tc_o(tc_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk_all(input string tag, input int c, input int t, input int d);
    chk({tag, ".count"}, int'(count_o), c);
    chk({tag, ".tc"}, int'(tc_o), t);
    chk({tag, ".done"}, int'(done_o), d);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value_i = v;
    load_i = 1'b1;
    cyc();
    load_i = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear_i = 0; load_i = 0; enable_i = 0; dir_i = 0;
    mode_i = 2'b00; load_value_i = 0; limit_i = 16'hFFFF; prescale_i = 0;
    #3;
    chk_all("reset", 0, 0, 0);
    #9;
    reset_n = 1'b1;
    cyc();
    chk_all("post_reset_idle", 0, 0, 0);

    do_load(16'h0040);
    enable_i = 1'b1;
    cyc(); cyc();
    chk("count_0x42", int'(count_o), 'h42);
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0);
    cyc();
    chk_all("reset_held", 0, 0, 0);
    reset_n = 1'b1;
    enable_i = 1'b0;

    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    limit_i = 9; prescale_i = 0; mode_i = 2'b00; dir_i = 0; enable_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk($sformatf("wrap_up%0d.count", i), int'(count_o), i % 10);
      chk($sformatf("wrap_up%0d.tc", i), int'(tc_o), int'(i == 10));
    end
    enable_i = 1'b0;

    dir_i = 1'b1; limit_i = 5;
    do_load(16'd2);
    enable_i = 1'b1;
    begin
      int exp_c[4] = '{1, 0, 5, 4};
      int exp_t[4] = '{0, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
        cyc();
        chk($sformatf("wrap_dn%0d.count", i), int'(count_o), exp_c[i]);
        chk($sformatf("wrap_dn%0d.tc", i), int'(tc_o), exp_t[i]);
      end
    end
    enable_i = 1'b0;
    clear_i = 1'b1; load_i = 1'b1; load_value_i = 16'd7;
    cyc();
    clear_i = 1'b0; load_i = 1'b0;
    chk("clear_over_load", int'(count_o), 0);

    dir_i = 1'b0; limit_i = 16'hFFFF; prescale_i = 3; enable_i = 1'b1;
    begin
      int exp_c[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2};
      logic en_v[10] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
      for (int i = 0; i < 10; i++) begin
        enable_i = en_v[i];
        cyc();
        chk($sformatf("prescale%0d", i), int'(count_o), exp_c[i]);
      end
    end
    enable_i = 1'b0;

    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    mode_i = 2'b10; limit_i = 3; prescale_i = 0; enable_i = 1'b1;
    cyc(); chk_all("os1", 1, 0, 0);
    cyc(); chk_all("os2", 2, 0, 0);
    cyc(); chk_all("os3", 3, 0, 0);
    cyc(); chk_all("os_term", 3, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_all($sformatf("os_done%0d", i), 3, 0, 1);
    end
    do_load(16'd0);
    chk_all("os_reload", 0, 0, 0);
    cyc();
    chk_all("os_resume", 1, 0, 0);
    enable_i = 1'b0;

    mode_i = 2'b01; dir_i = 1'b1;
    do_load(16'd1);
    enable_i = 1'b1;
    cyc(); chk_all("sat0", 0, 0, 0);
    cyc(); chk_all("sat1", 0, 1, 0);
    cyc(); chk_all("sat2", 0, 1, 0);
    enable_i = 1'b0;

    mode_i = 2'b00; dir_i = 1'b0; limit_i = 9;
    do_load(16'hFFFE);
    enable_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk($sformatf("above%0d.count", i), int'(count_o), (i == 1) ? 'hFFFF : (i - 2) % 10);
      chk($sformatf("above%0d.tc", i), int'(tc_o), int'(i == 12));
    end
    enable_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
